// File: rtl/eeprom_arb_pkg.sv
// Shared types for the save-RAM arbiter.
//   state_t : arbiter sequencing (idle, memory access in flight, completion)
//   grant_t : which requester owns the current access
//   TO_W    : width of the memory-side timeout counter
package eeprom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE
  } state_t;

  typedef enum logic {
    GNT_EE,
    GNT_HOST
  } grant_t;

  localparam int TO_W = 10;

endpackage

// File: rtl/eeprom_ram_arbiter.sv
// eeprom_ram_arbiter
// Shares one save-RAM port between the serial-EEPROM emulator and the host
// save-file loader. Two-way round-robin arbitration, one access in flight,
// and a timeout guard on the memory side.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   ee_addr/ee_wdata/ee_rd/ee_wr       EEPROM byte request (level, held until ee_done)
//   ee_rdata/ee_done                   EEPROM completion (level, held until request drops)
//   host_req/host_we/host_addr/...     host request (level, held until host_ack)
//   host_rdata/host_ack                host completion (one-cycle pulse)
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_rdata/mem_ack                  memory completion
//   err                                sticky memory-timeout flag
//
// Optional feature (macro EEPROM_DIRTY_EN): adds dirty (out) / dirty_clr (in).
// dirty is set by every EEPROM write that the memory acknowledged and cleared
// by dirty_clr; a set on the same cycle as a clear wins.
module eeprom_ram_arbiter
  import eeprom_arb_pkg::*;
#(
  parameter int                MEM_AW  = 18,
  parameter logic [MEM_AW-1:0] BASE    = '0,
  parameter int                TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        ee_addr,
  input  logic [7:0]        ee_wdata,
  input  logic              ee_rd,
  input  logic              ee_wr,
  output logic [7:0]        ee_rdata,
  output logic              ee_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [7:0]        host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              err
`ifdef EEPROM_DIRTY_EN
  ,
  output logic              dirty,
  input  logic              dirty_clr
`endif
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t          state;
  grant_t          grant;
  grant_t          last_grant;
  logic [TO_W-1:0] to_cnt;

  logic            ee_pend;
  logic            ee_wins;
  logic            finish;
  logic [7:0]      done_byte;

  // A completed EEPROM access must not be re-requested while its done is still visible.
  assign ee_pend   = (ee_rd | ee_wr) & ~ee_done;
  // On a tie, the side that was not served last gets the port.
  assign ee_wins   = ee_pend && (!host_req || last_grant == GNT_HOST);
  // An ack on the timeout cycle still counts as a successful access.
  assign finish    = mem_ack || (to_cnt == TO_LIM);
  assign done_byte = mem_ack ? mem_rdata : 8'hFF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= GNT_EE;
      last_grant <= GNT_HOST;
      to_cnt     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      ee_rdata   <= 8'h00;
      ee_done    <= 1'b0;
      host_rdata <= 8'h00;
      host_ack   <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ee_pend || host_req) begin
            // Request fields are latched here so later input changes cannot disturb the access.
            if (ee_wins) begin
              grant     <= GNT_EE;
              mem_we    <= ee_wr;
              mem_addr  <= BASE + {{(MEM_AW-8){1'b0}}, ee_addr};
              mem_wdata <= ee_wdata;
            end else begin
              grant     <= GNT_HOST;
              mem_we    <= host_we;
              mem_addr  <= BASE + {{(MEM_AW-8){1'b0}}, host_addr};
              mem_wdata <= host_wdata;
            end
            mem_req <= 1'b1;
            to_cnt  <= '0;
            state   <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (finish) begin
            mem_req <= 1'b0;
            state   <= ST_DONE;
            if (!mem_ack) begin
              err <= 1'b1;
            end
            // Writes leave the read byte alone unless the access timed out.
            if (grant == GNT_EE) begin
              ee_done <= 1'b1;
              if (!mem_we || !mem_ack) begin
                ee_rdata <= done_byte;
              end
            end else begin
              host_ack <= 1'b1;
              if (!mem_we || !mem_ack) begin
                host_rdata <= done_byte;
              end
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_DONE: begin
          if (grant == GNT_EE) begin
            if (!ee_rd && !ee_wr) begin
              ee_done    <= 1'b0;
              last_grant <= GNT_EE;
              state      <= ST_IDLE;
            end
          end else begin
            host_ack   <= 1'b0;
            last_grant <= GNT_HOST;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef EEPROM_DIRTY_EN
  logic ee_write_ok;

  assign ee_write_ok = (state == ST_ISSUE) && (grant == GNT_EE) && mem_we && mem_ack;

  // Tracks whether the save image has EEPROM writes the host has not collected yet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dirty <= 1'b0;
    end else if (ee_write_ok) begin
      dirty <= 1'b1;
    end else if (dirty_clr) begin
      dirty <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_eeprom_ram_arbiter.sv
// tb_eeprom_ram_arbiter
// Randomised scoreboard bench for eeprom_ram_arbiter. A behavioural model
// (byte array, round-robin "who went last" flag, sticky error/dirty flags)
// predicts every memory access and every completion; a memory responder and a
// completion monitor pop those predictions and compare against the DUT.
// Honours EEPROM_DIRTY_EN to exercise the dirty flag.
module tb_eeprom_ram_arbiter;

  localparam logic [17:0] TB_BASE = 18'h3FF80;
  localparam int          TB_TO   = 12;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  ee_addr, ee_wdata, ee_rdata;
  logic        ee_rd, ee_wr, ee_done;
  logic        host_req, host_we, host_ack;
  logic [7:0]  host_addr, host_wdata, host_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        err;
`ifdef EEPROM_DIRTY_EN
  logic        dirty;
  logic        dirty_clr;
`endif

  always #5 clk = ~clk;

  eeprom_ram_arbiter #(
    .MEM_AW (18),
    .BASE   (TB_BASE),
    .TIMEOUT(TB_TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ee_addr   (ee_addr),
    .ee_wdata  (ee_wdata),
    .ee_rd     (ee_rd),
    .ee_wr     (ee_wr),
    .ee_rdata  (ee_rdata),
    .ee_done   (ee_done),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_ack  (host_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
`ifdef EEPROM_DIRTY_EN
    ,
    .dirty     (dirty),
    .dirty_clr (dirty_clr)
`endif
  );

  typedef struct {
    logic       is_ee;
    logic       we;
    logic       both;
    logic [7:0] off;
    logic [7:0] wdata;
    int         lat;
    logic       tmo;
  } txn_t;

  typedef struct {
    logic [17:0] addr;
    logic        we;
    logic [7:0]  wdata;
    int          lat;
    logic        tmo;
    logic        abort;
  } mem_t;

  typedef struct {
    logic [7:0] rdata;
    logic       chk_rd;
    logic       err;
    logic       dirty;
  } resp_t;

  mem_t  mem_q[$];
  resp_t ee_q[$];
  resp_t host_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] mdl_mem [256];
  logic       err_mdl;
  logic       dirty_mdl;
  logic       last_ee_mdl;

  // Memory behind the DUT
  logic [7:0] ram [logic [17:0]];

  function automatic logic [7:0] init_byte(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  function automatic logic [17:0] phys(input logic [7:0] off);
    int s;
    s = (int'(TB_BASE) + int'(off)) % 262144;
    return s[17:0];
  endfunction

  function automatic logic [7:0] ram_rd(input logic [17:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name, input string what);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic txn_t rand_txn(input logic is_ee);
    txn_t t;
    t.is_ee = is_ee;
    t.we    = 1'($urandom_range(0, 1));
    t.both  = is_ee && t.we && ($urandom_range(0, 2) == 0);
    // Offsets straddle 8'h80, where BASE + offset wraps past the top of memory.
    t.off   = 8'h78 + 8'($urandom_range(0, 15));
    t.wdata = 8'($urandom);
    t.lat   = $urandom_range(0, 3);
    t.tmo   = ($urandom_range(0, 9) == 0);
    return t;
  endfunction

  function automatic txn_t mk_txn(input logic is_ee, input logic we, input logic [7:0] off,
                                  input logic [7:0] wdata, input int lat, input logic tmo);
    txn_t t;
    t.is_ee = is_ee;
    t.we    = we;
    t.both  = 1'b0;
    t.off   = off;
    t.wdata = wdata;
    t.lat   = lat;
    t.tmo   = tmo;
    return t;
  endfunction

  // Predict the effect of one served access, in the order it will be served.
  task automatic model_serve(input txn_t t, input logic clr);
    mem_t  m;
    resp_t r;
    m.addr  = phys(t.off);
    m.we    = t.we;
    m.wdata = t.wdata;
    m.lat   = t.lat;
    m.tmo   = t.tmo;
    m.abort = 1'b0;
    r.chk_rd = !t.we || t.tmo;
    r.rdata  = 8'h00;
    if (t.tmo) begin
      r.rdata = 8'hFF;
      err_mdl = 1'b1;
    end else if (t.we) begin
      mdl_mem[t.off] = t.wdata;
    end else begin
      r.rdata = mdl_mem[t.off];
    end
    if (clr) dirty_mdl = 1'b0;
    if (t.is_ee && t.we && !t.tmo) dirty_mdl = 1'b1;
    r.err   = err_mdl;
    r.dirty = dirty_mdl;
    mem_q.push_back(m);
    if (t.is_ee) ee_q.push_back(r);
    else host_q.push_back(r);
    last_ee_mdl = t.is_ee;
  endtask

  task automatic ee_drive(input txn_t t);
    int   k;
    int   h;
    logic got;
    ee_addr  = t.off;
    ee_wdata = t.wdata;
    ee_wr    = t.we;
    ee_rd    = !t.we || t.both;
    k   = 0;
    got = 1'b0;
    while (k < 400 && !got) begin
      @(posedge clk); #1;
      got = ee_done;
      k++;
    end
    if (!got) report_fail("ee_done_wait", "ee_done never rose");
`ifdef EEPROM_DIRTY_EN
    dirty_clr = 1'b0;
`endif
    h = $urandom_range(0, 2);
    repeat (h) begin
      @(posedge clk); #1;
      check_output("ee_done_hold", ee_done, 1);
    end
    ee_rd = 1'b0;
    ee_wr = 1'b0;
    @(posedge clk); #1;
    check_output("ee_done_release", ee_done, 0);
  endtask

  task automatic host_drive(input txn_t t);
    int   k;
    logic got;
    host_addr  = t.off;
    host_wdata = t.wdata;
    host_we    = t.we;
    host_req   = 1'b1;
    k   = 0;
    got = 1'b0;
    while (k < 400 && !got) begin
      @(posedge clk); #1;
      got = host_ack;
      k++;
    end
    if (!got) report_fail("host_ack_wait", "host_ack never pulsed");
    host_req = 1'b0;
`ifdef EEPROM_DIRTY_EN
    dirty_clr = 1'b0;
`endif
    @(posedge clk); #1;
    check_output("host_ack_pulse", host_ack, 0);
  endtask

  // One transaction, or an EEPROM/host pair raised on the same cycle (tie).
  task automatic apply_stimulus(input txn_t a, input txn_t b, input logic tie, input logic clr);
    @(posedge clk); #1;
    if (!tie) begin
      model_serve(a, clr);
`ifdef EEPROM_DIRTY_EN
      dirty_clr = clr;
`endif
      if (a.is_ee) ee_drive(a);
      else host_drive(a);
    end else begin
      if (last_ee_mdl) begin
        model_serve(a, 1'b0);
        model_serve(b, 1'b0);
      end else begin
        model_serve(a, 1'b0);
        model_serve(b, 1'b0);
      end
      fork
        ee_drive(a);
        host_drive(b);
      join
    end
  endtask

  task automatic apply_tie(input txn_t a, input txn_t b);
    // Round-robin: whichever side was served last loses the tie.
    if (last_ee_mdl) begin
      @(posedge clk); #1;
      model_serve(b, 1'b0);
      model_serve(a, 1'b0);
      fork
        ee_drive(a);
        host_drive(b);
      join
    end else begin
      apply_stimulus(a, b, 1'b1, 1'b0);
    end
  endtask

  // Memory responder: checks each access against the prediction and answers it.
  task automatic serve_mem();
    mem_t p;
    int   n;
    if (mem_q.size() == 0) begin
      report_fail("mem_unexpected", "access with nothing predicted");
      p.addr = mem_addr; p.we = mem_we; p.wdata = mem_wdata;
      p.lat = 0; p.tmo = 1'b0; p.abort = 1'b0;
    end else begin
      p = mem_q.pop_front();
    end
    check_output("mem_addr", mem_addr, p.addr);
    check_output("mem_we", mem_we, p.we);
    if (p.we) check_output("mem_wdata", mem_wdata, p.wdata);
    if (p.abort || p.tmo) begin
      n = 1;
      while (mem_req && n < TB_TO + 20) begin
        @(posedge clk); #1;
        if (mem_req) n++;
      end
      if (p.tmo) begin
        n_cmp++;
        if (mem_req || n < TB_TO || n > TB_TO + 1) begin
          n_fail++;
          $display("[TB] FAIL timeout_len: mem_req held %0d cycles, required %0d..%0d", n, TB_TO, TB_TO + 1);
        end
      end else begin
        check_output("mem_req_abort", mem_req, 0);
      end
    end else begin
      repeat (p.lat) begin
        @(posedge clk); #1;
      end
      check_output("mem_req_held", mem_req, 1);
      mem_ack   = 1'b1;
      mem_rdata = mem_we ? 8'($urandom) : ram_rd(mem_addr);
      if (mem_we) ram[mem_addr] = mem_wdata;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      check_output("mem_req_drop", mem_req, 0);
    end
  endtask

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (reset_n && mem_req) serve_mem();
    end
  end

  // Completion monitor
  logic  ack_prev  = 1'b0;
  logic  done_prev = 1'b0;
  resp_t mon_r;

  always @(negedge clk) begin
    if (!reset_n) begin
      ack_prev  = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (host_ack) begin
        check_output("host_ack_single", ack_prev, 0);
        if (host_q.size() == 0) begin
          report_fail("host_unexpected", "host_ack with nothing predicted");
        end else begin
          mon_r = host_q.pop_front();
          if (mon_r.chk_rd) check_output("host_rdata", host_rdata, mon_r.rdata);
          check_output("host_err", err, mon_r.err);
`ifdef EEPROM_DIRTY_EN
          check_output("host_dirty", dirty, mon_r.dirty);
`endif
        end
      end
      if (ee_done && !done_prev) begin
        if (ee_q.size() == 0) begin
          report_fail("ee_unexpected", "ee_done with nothing predicted");
        end else begin
          mon_r = ee_q.pop_front();
          if (mon_r.chk_rd) check_output("ee_rdata", ee_rdata, mon_r.rdata);
          check_output("ee_err", err, mon_r.err);
`ifdef EEPROM_DIRTY_EN
          check_output("ee_dirty", dirty, mon_r.dirty);
`endif
        end
      end
      ack_prev  = host_ack;
      done_prev = ee_done;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t a;
    txn_t b;
    int   r;
    reset_n    = 1'b0;
    ee_addr    = 8'h00;
    ee_wdata   = 8'h00;
    ee_rd      = 1'b0;
    ee_wr      = 1'b0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = 8'h00;
    host_wdata = 8'h00;
`ifdef EEPROM_DIRTY_EN
    dirty_clr  = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_byte(phys(8'(i)));
    err_mdl     = 1'b0;
    dirty_mdl   = 1'b0;
    last_ee_mdl = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_mem_req", mem_req, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_ee_done", ee_done, 0);
    check_output("rst_ee_rdata", ee_rdata, 0);
    check_output("rst_host_ack", host_ack, 0);
    check_output("rst_host_rdata", host_rdata, 0);
    check_output("rst_err", err, 0);
`ifdef EEPROM_DIRTY_EN
    check_output("rst_dirty", dirty, 0);
`endif
    reset_n = 1'b1;

    $display("[TB] EEPROM read of 8'h12 with 3-cycle memory latency");
    a = mk_txn(1'b1, 1'b0, 8'h12, 8'h00, 3, 1'b0);
    apply_stimulus(a, a, 1'b0, 1'b0);

    $display("[TB] simultaneous requests alternate");
    apply_tie(rand_txn(1'b1), rand_txn(1'b0));
    apply_tie(rand_txn(1'b1), rand_txn(1'b0));

    $display("[TB] host write at the wrap point, then read back");
    a = mk_txn(1'b0, 1'b1, 8'hFF, 8'h3C, 1, 1'b0);
    apply_stimulus(a, a, 1'b0, 1'b0);
    a = mk_txn(1'b1, 1'b0, 8'hFF, 8'h00, 0, 1'b0);
    apply_stimulus(a, a, 1'b0, 1'b0);

    $display("[TB] withheld ack, then a normal access");
    a = mk_txn(1'b1, 1'b0, 8'h20, 8'h00, 0, 1'b1);
    apply_stimulus(a, a, 1'b0, 1'b0);
    a = mk_txn(1'b0, 1'b0, 8'h20, 8'h00, 2, 1'b0);
    apply_stimulus(a, a, 1'b0, 1'b0);

`ifdef EEPROM_DIRTY_EN
    $display("[TB] dirty flag directed sequence");
    a = mk_txn(1'b0, 1'b1, 8'h05, 8'h11, 0, 1'b0);
    apply_stimulus(a, a, 1'b0, 1'b1);
    a = mk_txn(1'b1, 1'b1, 8'h06, 8'h22, 1, 1'b0);
    apply_stimulus(a, a, 1'b0, 1'b0);
    a = mk_txn(1'b0, 1'b1, 8'h07, 8'h33, 0, 1'b0);
    apply_stimulus(a, a, 1'b0, 1'b0);
    a = mk_txn(1'b1, 1'b1, 8'h08, 8'h44, 2, 1'b0);
    apply_stimulus(a, a, 1'b0, 1'b1);
`endif

    $display("[TB] randomised traffic");
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      if (r == 0) begin
        apply_tie(rand_txn(1'b1), rand_txn(1'b0));
      end else begin
        a = rand_txn(r[0]);
        apply_stimulus(a, a, 1'b0, ($urandom_range(0, 3) == 0));
      end
    end

    $display("[TB] reset during an access");
    @(posedge clk); #1;
    begin
      mem_t m;
      m.addr = phys(8'h44); m.we = 1'b0; m.wdata = 8'h00;
      m.lat = 0; m.tmo = 1'b0; m.abort = 1'b1;
      mem_q.push_back(m);
    end
    ee_addr = 8'h44;
    ee_rd   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("mem_req_before_reset", mem_req, 1);
    reset_n = 1'b0;
    #1;
    check_output("midrst_mem_req", mem_req, 0);
    check_output("midrst_ee_done", ee_done, 0);
    check_output("midrst_host_ack", host_ack, 0);
    check_output("midrst_err", err, 0);
    ee_rd       = 1'b0;
    err_mdl     = 1'b0;
    dirty_mdl   = 1'b0;
    last_ee_mdl = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    apply_tie(rand_txn(1'b1), rand_txn(1'b0));
    a = rand_txn(1'b0);
    apply_stimulus(a, a, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check_output("mem_q_drained", mem_q.size(), 0);
    check_output("ee_q_drained", ee_q.size(), 0);
    check_output("host_q_drained", host_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
